host_bus_if: RTL and testbench
==============================

# host_bus_if

Asynchronous host-bus front end for the VGA text controller. It synchronises the host strobes (`ncs`, `nrd`, `nwr`) into the `clk` domain and captures the register address and write data. It issues one valid/ready register request per host access to the control block, returns read data, and drives `wait_sig` to stretch the host cycle until the access completes. It sits between the top-level pins and the control block.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on each strobe input; legal values 2–3.
- `WAIT_TIMEOUT`, default 255: cycles allowed in REQ+WAIT_RSP before the access is aborted; legal values 1–255.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `nrst`  in  1  reset; asynchronous, active-low.
- `ncs`  in  1  host chip select, active-low, asynchronous.
- `nrd`  in  1  host read strobe, active-low, asynchronous.
- `nwr`  in  1  host write strobe, active-low, asynchronous.
- `ext_address`  in  4  host register address; stable while the strobe is active.
- `ext_data_in`  in  8  host write data; stable while `nwr` is low.
- `ext_data_out`  out  8  read data to the pad tristate.
- `wait_sig`  out  1  high = host must extend the cycle.
- `req_valid`  out  1  request to control.
- `req_write`  out  1  1 = write, 0 = read.
- `req_addr`  out  4  captured address.
- `req_wdata`  out  8  captured write data.
- `req_ready`  in  1  control accepts the request.
- `rsp_valid`  in  1  one-cycle read-data strobe from control.
- `rsp_rdata`  in  8  read data; valid when `rsp_valid` is high.
- `timeout_err`  out  1  one-cycle pulse when an access is aborted by timeout.

## Operation
- **Synchroniser.** Each strobe passes through `SYNC_STAGES` flops, all reset to 1. The synchronised strobes are `cs_s`, `rd_s` and `wr_s`, each active-high after inversion.
- **Active access.**
  - `acc_rd` = `cs_s & rd_s & ~wr_s`.
  - `acc_wr` = `cs_s & wr_s & ~rd_s`.
  - Both strobes low is illegal and is treated as no access.
- **IDLE.** `wait_sig` = 0 and `req_valid` = 0. On `acc_rd` or `acc_wr`:
  - capture `ext_address` into `req_addr`;
  - capture `ext_data_in` into `req_wdata` (writes only);
  - set `req_write`;
  - clear the timeout counter;
  - set `wait_sig` = 1 and `req_valid` = 1;
  - move to REQ.
- **REQ.** Hold `req_valid`, `req_addr`, `req_wdata` and `req_write` constant until the cycle where `req_valid & req_ready`. That cycle:
  - clear `req_valid`;
  - write: clear `wait_sig` and go to HOLD;
  - read: go to WAIT_RSP.
- **WAIT_RSP.** On `rsp_valid`:
  - load `rsp_rdata` into `ext_data_out`;
  - clear `wait_sig`;
  - go to HOLD.
  - `rsp_valid` arriving in any other state is ignored.
- **HOLD.** Stay until neither `acc_rd` nor `acc_wr` is true, then go to IDLE. This guarantees exactly one request per host strobe.
- **Timeout.**
  - The 8-bit counter increments every cycle in REQ and WAIT_RSP and saturates.
  - When the counter equals `WAIT_TIMEOUT` and the access is still incomplete:
    - clear `req_valid` and `wait_sig`;
    - set `ext_data_out` = 8'hFF (reads only);
    - pulse `timeout_err` for one cycle;
    - go to HOLD.
  - If the access completes on that same cycle, completion wins and there is no error.
- **Host abort.** A strobe that deasserts during REQ or WAIT_RSP does not cancel the access; the FSM finishes the access normally. After completion, HOLD falls through to IDLE on the next cycle.
- **`ext_data_out`.** Holds its last value outside reads; writes do not change it.
- **Reset.** `nrst` low mid-access forces IDLE immediately. All outputs return to reset values without completing the handshake. The control block must tolerate a `req_valid` that drops this way.

## Timing
- Reset values:
  - `wait_sig` = 0, `req_valid` = 0, `req_write` = 0;
  - `req_addr` = 0, `req_wdata` = 0, `ext_data_out` = 8'h00;
  - `timeout_err` = 0;
  - state IDLE, synchroniser flops = 1.
- Strobe low at the pin → `wait_sig` and `req_valid` high: `SYNC_STAGES`+1 rising edges. The host must not sample `wait_sig` earlier than this.
- Write with `req_ready` already high: `wait_sig` falls on the edge after the REQ cycle, so `wait_sig` is high for 1 cycle.
- Read: `ext_data_out` updates and `wait_sig` falls on the same edge, the one after `rsp_valid` is sampled.
- Back-to-back accesses: at least one IDLE cycle with strobes inactive (post-sync) between requests.
- Timeout: abort occurs `WAIT_TIMEOUT` cycles after entry to REQ.

## Test plan
- **Write, ready tied high.** `ncs`=0, `nwr`=0, addr 4'h3, data 8'hA5 → one `req_valid` cycle with `req_write`=1, `req_addr`=3, `req_wdata`=A5. `wait_sig` is high for exactly 1 cycle, and there is no second request while the strobe is held for 20 cycles.
- **Read with 5-cycle response.** Read addr 4'hC; control pulses `rsp_valid` with 8'h5A five cycles after accept → `ext_data_out`=5A and `wait_sig` drops on the same edge.
- **Backpressure.** `req_ready` low for 10 cycles → `req_valid` and the request fields are stable all 10 cycles; exactly one transfer occurs.
- **Timeout.** `WAIT_TIMEOUT`=16, read, no `rsp_valid` → `timeout_err` pulses once at cycle 16, `ext_data_out`=FF, `wait_sig`=0. A late `rsp_valid` is ignored.
- **Illegal strobe, then reset.**
  - `nrd` and `nwr` both low → no request.
  - Then start a read and assert `nrst` low during WAIT_RSP → all outputs return to reset values immediately and the FSM is in IDLE after release.
- **Host abort.** Strobe released 1 cycle after `req_valid` rises → the request still completes, and the FSM returns to IDLE 1 cycle after HOLD.

Source files
------------

// File: rtl/host_bus_if.sv
// Host-bus front end: synchronises the asynchronous host strobes, issues one
// valid/ready register request per host access and stretches the host cycle via wait_sig.
module host_bus_if #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       ncs,
    input  logic       nrd,
    input  logic       nwr,
    input  logic [3:0] ext_address,
    input  logic [7:0] ext_data_in,
    output logic [7:0] ext_data_out,
    output logic       wait_sig,
    output logic       req_valid,
    output logic       req_write,
    output logic [3:0] req_addr,
    output logic [7:0] req_wdata,
    input  logic       req_ready,
    input  logic       rsp_valid,
    input  logic [7:0] rsp_rdata,
    output logic       timeout_err
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitRsp, StHold} state_e;

    localparam logic [7:0] TimeoutVal = 8'(WAIT_TIMEOUT);

    logic [SYNC_STAGES-1:0] cs_sync_q, rd_sync_q, wr_sync_q;
    logic                   cs_s, rd_s, wr_s;
    logic                   acc_rd, acc_wr;

    state_e     state_q;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_hit;
    logic       wait_q, valid_q, write_q, terr_q;
    logic [3:0] addr_q;
    logic [7:0] wdata_q, dout_q;

    // Synchroniser chains idle at 1 so a reset never looks like an active strobe.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cs_sync_q <= '1;
            rd_sync_q <= '1;
            wr_sync_q <= '1;
        end else begin
            cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], ncs};
            rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], nrd};
            wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], nwr};
        end
    end

    assign cs_s   = ~cs_sync_q[SYNC_STAGES-1];
    assign rd_s   = ~rd_sync_q[SYNC_STAGES-1];
    assign wr_s   = ~wr_sync_q[SYNC_STAGES-1];
    assign acc_rd = cs_s & rd_s & ~wr_s;
    assign acc_wr = cs_s & wr_s & ~rd_s;

    // Saturating count of cycles spent in REQ and WAIT_RSP, including the current one.
    always_comb begin
        cnt_d       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        timeout_hit = (cnt_d == TimeoutVal);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            wait_q  <= 1'b0;
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 4'd0;
            wdata_q <= 8'd0;
            dout_q  <= 8'h00;
            terr_q  <= 1'b0;
        end else begin
            terr_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (acc_rd || acc_wr) begin
                        addr_q <= ext_address;
                        if (acc_wr) begin
                            wdata_q <= ext_data_in;
                        end
                        write_q <= acc_wr;
                        cnt_q   <= 8'd0;
                        wait_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    cnt_q <= cnt_d;
                    if (req_ready && write_q) begin
                        valid_q <= 1'b0;
                        wait_q  <= 1'b0;
                        state_q <= StHold;
                    end else if (timeout_hit) begin
                        // A read accepted on the timeout cycle is still incomplete: abort.
                        valid_q <= 1'b0;
                        wait_q  <= 1'b0;
                        terr_q  <= 1'b1;
                        if (!write_q) begin
                            dout_q <= 8'hFF;
                        end
                        state_q <= StHold;
                    end else if (req_ready) begin
                        valid_q <= 1'b0;
                        state_q <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    cnt_q <= cnt_d;
                    if (rsp_valid) begin
                        dout_q  <= rsp_rdata;
                        wait_q  <= 1'b0;
                        state_q <= StHold;
                    end else if (timeout_hit) begin
                        wait_q  <= 1'b0;
                        terr_q  <= 1'b1;
                        dout_q  <= 8'hFF;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (!(acc_rd || acc_wr)) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ext_data_out = dout_q;
    assign wait_sig     = wait_q;
    assign req_valid    = valid_q;
    assign req_write    = write_q;
    assign req_addr     = addr_q;
    assign req_wdata    = wdata_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_host_bus_if.sv
// Directed bench for host_bus_if: expected requests are queued as stimulus is driven and
// checked by a monitor when the request handshake completes.
module tb_host_bus_if;

    localparam int unsigned SyncStages  = 2;
    localparam int unsigned WaitTimeout = 16;

    logic       clk = 1'b0;
    logic       nrst;
    logic       ncs, nrd, nwr;
    logic [3:0] ext_address;
    logic [7:0] ext_data_in;
    logic [7:0] ext_data_out;
    logic       wait_sig, req_valid, req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_ready, rsp_valid;
    logic [7:0] rsp_rdata;
    logic       timeout_err;

    host_bus_if #(
        .SYNC_STAGES (SyncStages),
        .WAIT_TIMEOUT(WaitTimeout)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .ncs         (ncs),
        .nrd         (nrd),
        .nwr         (nwr),
        .ext_address (ext_address),
        .ext_data_in (ext_data_in),
        .ext_data_out(ext_data_out),
        .wait_sig    (wait_sig),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
    } req_t;

    req_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_xfer  = 0;
    int   n_exp_xfer = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until req_valid is seen; 99 if it never arrives.
    task automatic wait_req(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!req_valid && n < 40);
        if (!req_valid) n = 99;
    endtask

    task automatic push_req(input logic wr, input logic [3:0] addr, input logic [7:0] wdata);
        req_t r;
        r.wr    = wr;
        r.addr  = addr;
        r.wdata = wdata;
        exp_q.push_back(r);
        n_exp_xfer++;
    endtask

    // Scoreboard monitor: every accepted request must match the oldest expected one.
    always @(negedge clk) begin
        if (nrst && req_valid && req_ready) begin
            req_t e;
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("unexpected_request", 32'(req_addr), 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("req_write", 32'(req_write), 32'(e.wr));
                check("req_addr", 32'(req_addr), 32'(e.addr));
                if (e.wr) check("req_wdata", 32'(req_wdata), 32'(e.wdata));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int lat;
    int bad;

    initial begin
        nrst = 1'b0;
        ncs = 1'b1; nrd = 1'b1; nwr = 1'b1;
        ext_address = 4'h0; ext_data_in = 8'h00;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 8'h00;
        #3;
        check("rst_wait", 32'(wait_sig), 0);
        check("rst_valid", 32'(req_valid), 0);
        check("rst_write", 32'(req_write), 0);
        check("rst_addr", 32'(req_addr), 0);
        check("rst_wdata", 32'(req_wdata), 0);
        check("rst_dout", 32'(ext_data_out), 0);
        check("rst_terr", 32'(timeout_err), 0);
        tick(2);
        nrst = 1'b1;
        tick(2);

        // Write with ready tied high.
        req_ready = 1'b1;
        push_req(1'b1, 4'h3, 8'hA5);
        ncs = 1'b0; nwr = 1'b0; ext_address = 4'h3; ext_data_in = 8'hA5;
        wait_req(lat);
        check("wr_latency", 32'(lat), SyncStages + 1);
        check("wr_wait_hi", 32'(wait_sig), 1);
        tick(1);
        check("wr_wait_lo", 32'(wait_sig), 0);
        check("wr_valid_lo", 32'(req_valid), 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (req_valid || wait_sig) bad++;
        end
        check("wr_no_second_req", 32'(bad), 0);
        check("wr_dout_kept", 32'(ext_data_out), 32'h00);
        ncs = 1'b1; nwr = 1'b1;
        tick(4);

        // Read with a response five cycles after accept.
        push_req(1'b0, 4'hC, 8'h00);
        ncs = 1'b0; nrd = 1'b0; ext_address = 4'hC;
        wait_req(lat);
        check("rd_latency", 32'(lat), SyncStages + 1);
        tick(1);
        check("rd_wait_during", 32'(wait_sig), 1);
        tick(4);
        rsp_valid = 1'b1; rsp_rdata = 8'h5A;
        check("rd_dout_before", 32'(ext_data_out), 32'h00);
        tick(1);
        rsp_valid = 1'b0;
        check("rd_dout", 32'(ext_data_out), 32'h5A);
        check("rd_wait_lo", 32'(wait_sig), 0);
        ncs = 1'b1; nrd = 1'b1;
        tick(4);

        // Backpressure: request held stable for ten cycles.
        req_ready = 1'b0;
        push_req(1'b1, 4'h7, 8'h3C);
        ncs = 1'b0; nwr = 1'b0; ext_address = 4'h7; ext_data_in = 8'h3C;
        wait_req(lat);
        check("bp_latency", 32'(lat), SyncStages + 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!req_valid || !req_write || req_addr != 4'h7 || req_wdata != 8'h3C || !wait_sig)
                bad++;
            tick(1);
        end
        check("bp_stable", 32'(bad), 0);
        req_ready = 1'b1;
        tick(1);
        check("bp_valid_lo", 32'(req_valid), 0);
        check("bp_wait_lo", 32'(wait_sig), 0);
        check("bp_one_xfer", 32'(n_xfer), 32'(n_exp_xfer));
        ncs = 1'b1; nwr = 1'b1;
        tick(4);

        // Read timeout with no response.
        push_req(1'b0, 4'h9, 8'h00);
        ncs = 1'b0; nrd = 1'b0; ext_address = 4'h9;
        wait_req(lat);
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (!timeout_err && lat < 40);
        check("to_cycles", 32'(lat), WaitTimeout);
        check("to_dout", 32'(ext_data_out), 32'hFF);
        check("to_wait_lo", 32'(wait_sig), 0);
        check("to_valid_lo", 32'(req_valid), 0);
        rsp_valid = 1'b1; rsp_rdata = 8'h11;
        tick(1);
        rsp_valid = 1'b0;
        check("to_pulse_once", 32'(timeout_err), 0);
        tick(1);
        check("to_late_rsp_ignored", 32'(ext_data_out), 32'hFF);
        ncs = 1'b1; nrd = 1'b1;
        tick(4);

        // Illegal strobe combination issues nothing.
        ncs = 1'b0; nrd = 1'b0; nwr = 1'b0; ext_address = 4'h6;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (req_valid || wait_sig) bad++;
        end
        check("illegal_no_req", 32'(bad), 0);
        ncs = 1'b1; nrd = 1'b1; nwr = 1'b1;
        tick(4);

        // Reset during WAIT_RSP.
        push_req(1'b0, 4'h5, 8'h00);
        ncs = 1'b0; nrd = 1'b0; ext_address = 4'h5;
        wait_req(lat);
        tick(3);
        check("rst_mid_wait_hi", 32'(wait_sig), 1);
        nrst = 1'b0;
        #1;
        check("rst_mid_wait", 32'(wait_sig), 0);
        check("rst_mid_addr", 32'(req_addr), 0);
        check("rst_mid_write", 32'(req_write), 0);
        check("rst_mid_wdata", 32'(req_wdata), 0);
        check("rst_mid_dout", 32'(ext_data_out), 0);
        ncs = 1'b1; nrd = 1'b1;
        tick(2);
        nrst = 1'b1;
        tick(3);
        push_req(1'b1, 4'h1, 8'h0F);
        ncs = 1'b0; nwr = 1'b0; ext_address = 4'h1; ext_data_in = 8'h0F;
        wait_req(lat);
        check("post_rst_latency", 32'(lat), SyncStages + 1);
        tick(1);
        check("post_rst_wait_lo", 32'(wait_sig), 0);
        ncs = 1'b1; nwr = 1'b1;
        tick(4);

        // Host abort: strobe released one cycle after req_valid rises.
        req_ready = 1'b0;
        push_req(1'b1, 4'hA, 8'h77);
        ncs = 1'b0; nwr = 1'b0; ext_address = 4'hA; ext_data_in = 8'h77;
        wait_req(lat);
        tick(1);
        ncs = 1'b1; nwr = 1'b1;
        tick(3);
        check("abort_still_valid", 32'(req_valid), 1);
        req_ready = 1'b1;
        tick(1);
        check("abort_done_wait", 32'(wait_sig), 0);
        // Next access starts right away; it is only served if HOLD left after one cycle.
        push_req(1'b0, 4'h2, 8'h00);
        ncs = 1'b0; nrd = 1'b0; ext_address = 4'h2;
        wait_req(lat);
        check("abort_idle_latency", 32'(lat), SyncStages + 1);
        tick(1);
        rsp_valid = 1'b1; rsp_rdata = 8'h42;
        tick(1);
        rsp_valid = 1'b0;
        check("abort_next_dout", 32'(ext_data_out), 32'h42);
        ncs = 1'b1; nrd = 1'b1;
        tick(4);

        check("xfer_count", 32'(n_xfer), 32'(n_exp_xfer));
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
